delay_line_var: RTL and testbench

DELAY_LINE_VAR -- requirements
Module: delay_line_var

---
 rtl/delay_line_var.sv | 131 +++++++++++++
 tb/tb_delay_line_var.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/delay_line_var.sv
// Variable-length delay line with clock enable, flush and a deferred
// delay change that only takes effect once the line has drained.
//
// state | meaning
// IDLE  | nothing in flight, no delay change waiting
// RUN   | items in flight, no delay change waiting
// RECFG | delay change waiting for the line to drain
`timescale 1ns/1ps
module delay_line_var #(
  parameter int DATA_W  = 16,
  parameter int MAX_DLY = 16,
  parameter int RST_DLY = 3,
  localparam int DLY_W  = $clog2(MAX_DLY + 1)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              iCe,
  input  logic              iFlush,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iData,
  input  logic              iDelayLoad,
  input  logic [DLY_W-1:0]  iDelay,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic [DLY_W-1:0]  oDelay,
  output logic [DLY_W-1:0]  oCount,
  output logic              oBusy,
  output logic              oCfgErr
);

  typedef enum logic [1:0] {IDLE, RUN, RECFG} state_t;

  state_t              state;
  logic [MAX_DLY-1:0]  vld;
  logic [DATA_W-1:0]   dat [MAX_DLY];
  logic [DLY_W-1:0]    dly;
  logic [DLY_W-1:0]    pend_dly;
  logic [DLY_W-1:0]    count;
  logic [DLY_W-1:0]    count_nxt;
  logic                cfg_err;
  logic                sel_vld;
  logic [DATA_W-1:0]   sel_dat;
  logic                acc;
  logic                load_ok;
  logic                load_bad;
  logic                apply;

  assign acc      = iValid & iCe & ~iFlush;
  assign load_ok  = iDelayLoad && (iDelay != '0) && (iDelay <= DLY_W'(MAX_DLY));
  assign load_bad = iDelayLoad & ~load_ok;
  // A new delay is only safe once nothing is in flight, so stale stages can be wiped.
  assign apply    = iCe && (count == '0) && !acc && ((state == RECFG) || load_ok);

  // Output tap selected by the active delay (stage oDelay-1).
  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < MAX_DLY; k++) begin
      if (dly == DLY_W'(k + 1)) begin
        sel_vld = vld[k];
        sel_dat = dat[k];
      end
    end
  end

  assign oValid  = sel_vld & iCe;
  assign oData   = sel_dat;
  assign oDelay  = dly;
  assign oCount  = count;
  assign oCfgErr = cfg_err;
  assign oBusy   = (count != '0) || (state == RECFG);

  // Occupancy after this edge: flush wins, a stall holds.
  always_comb begin
    count_nxt = count;
    if (iFlush)
      count_nxt = '0;
    else if (iCe)
      count_nxt = count + DLY_W'(acc) - DLY_W'(oValid);
  end

  // Shift register; data always moves, valid bits are wiped on flush or delay change.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      vld <= '0;
      for (int k = 0; k < MAX_DLY; k++) dat[k] <= '0;
    end else begin
      if (iCe) begin
        vld[0] <= iValid & ~iFlush;
        dat[0] <= iData;
        for (int k = 1; k < MAX_DLY; k++) begin
          vld[k] <= vld[k-1];
          dat[k] <= dat[k-1];
        end
      end
      if (iFlush || apply) vld <= '0;
    end
  end

  // In-flight item counter.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) count <= '0;
    else        count <= count_nxt;
  end

  // Delay reconfiguration FSM with registered delay and error pulse.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      dly      <= DLY_W'(RST_DLY);
      pend_dly <= DLY_W'(RST_DLY);
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= load_bad;
      if (load_ok) pend_dly <= iDelay;
      if (apply)   dly      <= load_ok ? iDelay : pend_dly;
      case (state)
        IDLE, RUN: begin
          if (load_ok && !apply)    state <= RECFG;
          else if (count_nxt == '0) state <= IDLE;
          else                      state <= RUN;
        end
        RECFG: begin
          if (apply) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_line_var.sv
// Randomized and directed bench for delay_line_var against a queue-based model.
`timescale 1ns/1ps
module tb_delay_line_var;

  localparam int DATA_W  = 16;
  localparam int MAX_DLY = 16;
  localparam int RST_DLY = 3;
  localparam int DLY_W   = $clog2(MAX_DLY + 1);

  logic              aclk = 1'b0;
  logic              areset;
  logic              iCe, iFlush, iValid, iDelayLoad;
  logic [DATA_W-1:0] iData;
  logic [DLY_W-1:0]  iDelay;
  logic              oValid, oBusy, oCfgErr;
  logic [DATA_W-1:0] oData;
  logic [DLY_W-1:0]  oDelay, oCount;

  delay_line_var #(.DATA_W(DATA_W), .MAX_DLY(MAX_DLY), .RST_DLY(RST_DLY)) dut (
    .aclk(aclk), .areset(areset), .iCe(iCe), .iFlush(iFlush), .iValid(iValid),
    .iData(iData), .iDelayLoad(iDelayLoad), .iDelay(iDelay), .oValid(oValid),
    .oData(oData), .oDelay(oDelay), .oCount(oCount), .oBusy(oBusy), .oCfgErr(oCfgErr)
  );

  always #5 aclk = ~aclk;

  // Model: each in-flight item remembers how many enabled edges remain until it is visible.
  typedef struct {logic [DATA_W-1:0] d; int rem;} item_t;
  item_t q[$];
  int    mdly;
  logic  mpend;
  int    mpval;
  logic  merr;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mdly  = RST_DLY;
    mpend = 1'b0;
    mpval = 0;
    merr  = 1'b0;
  endtask

  // Called at posedge+1: drive inputs, check mid-cycle, then advance the model over the edge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic ce,
                      input logic fl, input logic ld, input logic [DLY_W-1:0] dl);
    logic exp_v, acc, lok, was_empty;
    int   old_dly;
    item_t it;
    iValid = v; iData = d; iCe = ce; iFlush = fl; iDelayLoad = ld; iDelay = dl;
    @(negedge aclk);
    exp_v = 1'b0;
    if (ce && q.size() > 0) exp_v = (q[0].rem == 0);
    chk("oValid", {31'd0, oValid}, {31'd0, exp_v});
    if (exp_v) chk("oData", {16'd0, oData}, {16'd0, q[0].d});
    chk("oDelay", 32'(oDelay), 32'(mdly));
    chk("oCount", 32'(oCount), 32'(q.size()));
    chk("oBusy", {31'd0, oBusy}, {31'd0, (q.size() != 0) || mpend});
    chk("oCfgErr", {31'd0, oCfgErr}, {31'd0, merr});
    @(posedge aclk);
    acc       = v && ce && !fl;
    lok       = ld && (dl != 0) && (int'(dl) <= MAX_DLY);
    merr      = ld && !lok;
    old_dly   = mdly;
    was_empty = (q.size() == 0);
    if (exp_v) void'(q.pop_front());
    if (fl) q.delete();
    else if (ce) begin
      foreach (q[i]) q[i].rem--;
      if (acc) begin
        it.d = d; it.rem = old_dly - 1;
        q.push_back(it);
      end
    end
    if (lok) begin mpend = 1'b1; mpval = int'(dl); end
    if (mpend && ce && was_empty && !acc) begin mdly = mpval; mpend = 1'b0; end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    iValid = 0; iData = 0; iCe = 0; iFlush = 0; iDelayLoad = 0; iDelay = 0;
    areset = 1'b1;
    model_reset();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;

    // Single item after reset.
    step(1'b1, 16'h00A5, 1'b1, 1'b0, 1'b0, '0);
    idle(5);

    // Stream of 10 with a 4-cycle stall in the middle.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'h1000 + 16'(i), 1'b1, 1'b0, 1'b0, '0);
      if (i == 4)
        for (int g = 0; g < 4; g++) step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, '0);
    end
    idle(6);

    // Reconfigure to 7 with two items in flight.
    step(1'b1, 16'h2001, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 16'h2002, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 5'd7);
    idle(6);
    step(1'b1, 16'h2003, 1'b1, 1'b0, 1'b0, '0);
    idle(9);

    // Illegal delay requests.
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 5'd0);
    idle(2);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 5'(MAX_DLY + 1));
    idle(2);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 5'd3);
    idle(2);

    // Flush with three in flight and a valid input in the flush cycle.
    step(1'b1, 16'h3001, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 16'h3002, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 16'h3003, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 16'h3BAD, 1'b1, 1'b1, 1'b0, '0);
    idle(6);

    // Asynchronous reset while a reconfiguration is pending.
    step(1'b1, 16'h4001, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 16'h4002, 1'b1, 1'b0, 1'b1, 5'd9);
    step(1'b1, 16'h4003, 1'b1, 1'b0, 1'b0, '0);
    chk("recfg_busy_before_reset", {31'd0, oBusy}, 32'd1);
    #2 areset = 1'b1;
    #1;
    chk("rst_oValid", {31'd0, oValid}, 32'd0);
    chk("rst_oCount", 32'(oCount), 32'd0);
    chk("rst_oDelay", 32'(oDelay), 32'(RST_DLY));
    chk("rst_oBusy", {31'd0, oBusy}, 32'd0);
    chk("rst_oCfgErr", {31'd0, oCfgErr}, 32'd0);
    model_reset();
    @(posedge aclk);
    #1 areset = 1'b0;
    step(1'b1, 16'h5001, 1'b1, 1'b0, 1'b0, '0);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 8,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5,
           5'($urandom_range(0, MAX_DLY + 2)));
    end
    idle(MAX_DLY + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
